// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit feeding the HI/LO registers of the single-cycle core.
// Latency: start sampled at E0, DONE pulse in the cycle after E0+Bits+1; issue interval Bits+3 cycles.
// Backpressure: no queueing; stall = busy & (start | rd_hilo) holds the core; starts while busy are dropped.
// Ports:
//   clk, reset_n                  core clock, async active-low reset
//   start, op, unsigned_instr     issue a mult/div (op: 0 mul, 1 div), signedness
//   operand_a, operand_b          rs / rt values, sampled only on an accepted start
//   rd_hilo                       mfhi/mflo decoded (stalls while busy)
//   busy, stall, done             status; done is a one-cycle pulse
//   hi_w, lo_w, hi_out, lo_out    HI/LO write strobes and result values
//   div_by_zero                   pulses with done for a divide with operand_b = 0
module muldiv_sequencer #(
  parameter int Bits = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            op,
  input  logic            unsigned_instr,
  input  logic [Bits-1:0] operand_a,
  input  logic [Bits-1:0] operand_b,
  input  logic            rd_hilo,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            hi_w,
  output logic            lo_w,
  output logic [Bits-1:0] hi_out,
  output logic [Bits-1:0] lo_out,
  output logic            div_by_zero
);

  localparam int CW = $clog2(Bits);
  localparam logic [CW-1:0] LAST = CW'(Bits - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic              op_r;
  logic              dbz_r;
  logic              neg_p;
  logic              neg_q;
  logic              neg_r;
  logic [Bits-1:0]   a_raw;
  logic [Bits-1:0]   mag_b;
  // Multiply: {partial high, multiplier shifting out}. Divide: {remainder, quotient}.
  logic [2*Bits-1:0] acc;

  logic [Bits-1:0]   mag_a_in;
  logic [Bits-1:0]   mag_b_in;
  logic              sign_ab;

  logic [Bits:0]     mul_sum;
  logic [2*Bits-1:0] mul_next;
  logic [2*Bits:0]   div_shift;
  logic              div_ge;
  logic [Bits-1:0]   div_diff;
  logic [2*Bits-1:0] div_next;
  logic [2*Bits-1:0] prod_fix;
  logic [Bits-1:0]   quo_fix;
  logic [Bits-1:0]   rem_fix;

  // Signedness is folded into magnitudes and sign flags at issue, so it need not be stored.
  always_comb begin
    mag_a_in = (!unsigned_instr && operand_a[Bits-1]) ? (Bits'(0) - operand_a) : operand_a;
    mag_b_in = (!unsigned_instr && operand_b[Bits-1]) ? (Bits'(0) - operand_b) : operand_b;
    sign_ab  = !unsigned_instr && (operand_a[Bits-1] ^ operand_b[Bits-1]);
  end

  always_comb begin
    // Shift-add: conditionally add the multiplicand into the high half, then shift right
    // with the carry entering at the top.
    mul_sum   = {1'b0, acc[2*Bits-1:Bits]} + (acc[0] ? {1'b0, mag_b} : {(Bits+1){1'b0}});
    mul_next  = {mul_sum, acc[Bits-1:1]};
    // Restoring step: compare the shifted remainder with one extra bit so its MSB is kept.
    // The difference is always below 2^Bits when taken, so a Bits-wide subtract is exact.
    div_shift = {acc, 1'b0};
    div_ge    = div_shift[2*Bits:Bits] >= {1'b0, mag_b};
    div_diff  = div_shift[2*Bits-1:Bits] - mag_b;
    div_next  = div_ge ? {div_diff, div_shift[Bits-1:1], 1'b1} : div_shift[2*Bits-1:0];
  end

  always_comb begin
    prod_fix = neg_p ? ((2*Bits)'(0) - acc) : acc;
    quo_fix  = dbz_r ? {Bits{1'b1}} : (neg_q ? (Bits'(0) - acc[Bits-1:0]) : acc[Bits-1:0]);
    // Divide by zero returns the raw dividend as remainder, never its magnitude.
    rem_fix  = dbz_r ? a_raw : (neg_r ? (Bits'(0) - acc[2*Bits-1:Bits]) : acc[2*Bits-1:Bits]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CALC;
      end
      CALC: if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    hi_w        = done;
    lo_w        = done;
    div_by_zero = done & dbz_r;
    stall       = busy & (start | rd_hilo);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      op_r   <= 1'b0;
      dbz_r  <= 1'b0;
      neg_p  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_raw  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_r  <= op;
          neg_p <= sign_ab;
          neg_q <= sign_ab;
          neg_r <= !unsigned_instr && operand_a[Bits-1];
          dbz_r <= op && (operand_b == '0);
          a_raw <= operand_a;
          mag_b <= mag_b_in;
          acc   <= {{Bits{1'b0}}, mag_a_in};
          cnt   <= '0;
        end
        CALC: begin
          acc <= op_r ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (op_r) begin
            hi_out <= rem_fix;
            lo_out <= quo_fix;
          end else begin
            hi_out <= prod_fix[2*Bits-1:Bits];
            lo_out <= prod_fix[Bits-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic        unsigned_instr = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        rd_hilo = 1'b0;
  logic        busy, stall, done, hi_w, lo_w, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.Bits(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .unsigned_instr(unsigned_instr), .operand_a(operand_a), .operand_b(operand_b),
    .rd_hilo(rd_hilo), .busy(busy), .stall(stall), .done(done), .hi_w(hi_w),
    .lo_w(lo_w), .hi_out(hi_out), .lo_out(lo_out), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic: {div_by_zero, hi, lo}.
  function automatic logic [64:0] model_op(input logic o, input logic u,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] p;
    logic [31:0] h, l;
    logic z;
    sa = $signed(a);
    sb = $signed(b);
    z  = 1'b0;
    if (!o) begin
      if (u) p = {32'b0, a} * {32'b0, b};
      else begin sp = sa * sb; p = sp; end
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      z = 1'b1;
      h = a;
      l = 32'hFFFF_FFFF;
    end else if (u) begin
      h = a % b;
      l = a / b;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
      p  = sq; l = p[31:0];
      p  = sr; h = p[31:0];
    end
    return {z, h, l};
  endfunction

  // Transaction-level model: an accepted start occupies Bits+2 cycles; the result
  // appears on entry to the last of them, which is the done cycle.
  int          m_left = 0;
  logic [64:0] m_pend = '0;
  logic [31:0] m_hi = '0, m_lo = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left <= 0;
      m_pend <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left == 0) begin
      if (start) begin
        m_pend <= model_op(op, unsigned_instr, operand_a, operand_b);
        m_left <= 34;
      end
    end else begin
      if (m_left == 2) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    logic eb, ed;
    eb = (m_left != 0);
    ed = (m_left == 1);
    chk("busy", busy, eb);
    chk("done", done, ed);
    chk("hi_w", hi_w, ed);
    chk("lo_w", lo_w, ed);
    chk("div_by_zero", div_by_zero, ed & m_pend[64]);
    chk("stall", stall, eb & (start | rd_hilo));
    chk("hi_out", hi_out, m_hi);
    chk("lo_out", lo_out, m_lo);
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_done(input int c0, output int cyc, output bit found);
    cyc = c0;
    found = 1'b0;
    while (!found && cyc <= 40) begin
      @(negedge clk);
      if (done === 1'b1) found = 1'b1;
      else begin
        @(posedge clk);
        cyc++;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Issue one op from idle; cycle 0 is the start cycle, so done is due in cycle 34.
  task automatic run_op(input string name, input logic o, input logic u,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic ez);
    int cyc;
    bit found;
    @(posedge clk); #1;
    start = 1'b1; op = o; unsigned_instr = u; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    wait_done(1, cyc, found);
    if (found) begin
      chk({name, "_latency"}, cyc, 34);
      chk({name, "_hi"}, hi_out, eh);
      chk({name, "_lo"}, lo_out, el);
      chk({name, "_dbz"}, div_by_zero, ez);
      chk({name, "_hilo_w"}, {hi_w, lo_w}, 2'b11);
      chk({name, "_stall_done"}, stall, rd_hilo);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_done_once"}, done, 1'b0);
      chk({name, "_stall_after"}, stall, 1'b0);
      chk({name, "_hi_held"}, hi_out, eh);
    end
  endtask

  initial begin
    int cyc;
    bit found;
    int pulses;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_hi", hi_out, 32'h0);
    chk("reset_lo", lo_out, 32'h0);
    reset_n = 1'b1;

    run_op("multu_max", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", 1'b0, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div_minm1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", 1'b1, 1'b1, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1);
    rd_hilo = 1'b1;
    run_op("div_zero_neg", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    rd_hilo = 1'b0;

    // Second start in cycle 5 must stall and be ignored.
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; unsigned_instr = 1'b1; operand_a = 32'd1234; operand_b = 32'd5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 1'b1; operand_a = 32'd99; operand_b = 32'd3;
    #1;
    chk("stall_on_busy_start", stall, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, cyc, found);
    if (found) begin
      chk("busy_start_lat", cyc, 34);
      chk("busy_start_lo", lo_out, 32'h006A_E9BC);
      chk("busy_start_hi", hi_out, 32'h0);
    end
    repeat (3) @(posedge clk);

    // Reset at CALC count 10 (cycle 11 after the start cycle).
    @(posedge clk); #1;
    start = 1'b1; op = 1'b0; unsigned_instr = 1'b0; operand_a = 32'hFFFF_FFFF; operand_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", busy, 1'b0);
    chk("midreset_hi", hi_out, 32'h0);
    chk("midreset_lo", lo_out, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (hi_w === 1'b1 || done === 1'b1) pulses++;
    end
    chk("midreset_no_pulse", pulses, 0);
    run_op("after_reset", 1'b1, 1'b1, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);

    // Random traffic, including starts while busy and mfhi/mflo reads.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      start          = ($urandom_range(0, 3) == 0);
      op             = 1'($urandom_range(0, 1));
      unsigned_instr = 1'($urandom_range(0, 1));
      operand_a      = pick();
      operand_b      = pick();
      rd_hilo        = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start = 1'b0;
    rd_hilo = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
